// File: rtl/mem_pkg.sv
// Shared types for the data-memory store buffer.
//   sb_entry_t  : one pending store (full byte address, byte flag, store data)
//   byte_extend : zero-extends a byte-store value the way dmem writes it
package mem_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        byte_en;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic [31:0] byte_extend(input logic [7:0] data);
    return {24'b0, data};
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: entry storage, head/tail pointers and occupancy count.
// Every entry and its valid bit are exposed so that the parent can forward
// pending stores to loads.
//   clk, reset  : clock, synchronous active-low reset (pointers/count only)
//   push, wentry: enqueue wentry at the tail
//   pop         : drop the head entry
//   entries     : raw storage, indexed by slot
//   valid_c     : per-slot occupancy, derived from head and count
//   head, tail  : slot pointers, wrap modulo DEPTH
//   count       : number of occupied slots
module sb_fifo
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  sb_entry_t       wentry,
  input  logic            pop,
  output sb_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0] valid_c,
  output logic [PW-1:0]   head,
  output logic [PW-1:0]   tail,
  output logic [CW-1:0]   count
);

  // Storage is intentionally left unreset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= wentry;
  end

  // Pointers and occupancy; full/empty are decided by count, not pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is valid when its distance from head is below the count.
  always_ff @(posedge clk) begin
  end

  always_comb begin
    valid_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_c[i] = CW'(PW'(PW'(i) - head)) < count;
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores retire into a FIFO in one cycle and drain in order whenever memory
// is ready; loads see pending stores via youngest-match forwarding.
//   clk, reset         : clock, synchronous active-low reset
//   MemWrite, MemByte  : core store request / byte store flag
//   DataAdr, WriteData : core byte address (loads and stores), store data
//   ReadData           : load data to core (combinational)
//   Stall              : core must hold this cycle
//   mem_we/byte/adr/wd : head entry presented to memory
//   mem_rd, mem_ready  : memory read data for DataAdr, write accept
//   Count              : number of pending stores
module dmem_store_buffer
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic          MemByte,
  input  logic [31:0]   DataAdr,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [31:0]   mem_adr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,
  input  logic          mem_ready,
  output logic [CW-1:0] Count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic             push;
  logic             pop;
  sb_entry_t        wentry;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid_c;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PW-1:0]    idx;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wentry  (wentry),
    .pop     (pop),
    .entries (entries),
    .valid_c (valid_c),
    .head    (head),
    .tail    (tail),
    .count   (Count)
  );

  // A full buffer still accepts a store when the head drains on the same edge.
  assign Stall  = MemWrite & (Count == CW'(DEPTH)) & ~mem_ready;
  assign push   = MemWrite & ~Stall;
  assign mem_we = (Count != '0);
  assign pop    = mem_we & mem_ready;

  assign wentry = '{addr:    DataAdr,
                    byte_en: MemByte,
                    data:    MemByte ? byte_extend(WriteData[7:0]) : WriteData};

  assign mem_adr  = entries[head].addr;
  assign mem_byte = entries[head].byte_en;
  assign mem_wd   = entries[head].data;

  // Youngest-match search, walking back from tail-1; first hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      idx = PW'(tail - PW'(k));
      if (!fwd_hit && valid_c[idx] &&
          (entries[idx].addr[31:2] == DataAdr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign ReadData = fwd_hit ? fwd_data : mem_rd;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: expected memory writes and load
// data are queued by the stimulus; a negedge monitor pops and compares.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        reset, MemWrite, MemByte, mem_ready;
  logic [31:0] DataAdr, WriteData;
  logic [31:0] ReadData, mem_adr, mem_wd, mem_rd;
  logic        Stall, mem_we, mem_byte;
  logic [2:0]  Count;

  logic [31:0] dmem [64];
  logic [31:0] refm [64];

  typedef struct {
    logic [31:0] adr;
    logic        b;
    logic [31:0] wd;
  } wr_t;

  wr_t         wq [$];
  logic [31:0] rq [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rand_mode = 1'b0;
  bit          chk_load  = 1'b0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemByte   (MemByte),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .Count     (Count)
  );

  // Behavioural data memory: async read at DataAdr, whole-word write.
  assign mem_rd = dmem[DataAdr[7:2]];
  always @(posedge clk) begin
    if (reset && mem_we && mem_ready) dmem[mem_adr[7:2]] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: memory writes happen at the next posedge when mem_we & mem_ready.
  always @(negedge clk) begin
    wr_t e;
    if (reset && mem_we && mem_ready) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got write to %h required no write", mem_adr);
      end else begin
        e = wq.pop_front();
        chk("wr_adr",  mem_adr,         e.adr);
        chk("wr_byte", 32'(mem_byte),   32'(e.b));
        chk("wr_data", mem_wd,          e.wd);
      end
    end
    if (chk_load) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_queue: got load with no expectation required one");
      end else begin
        chk("load", ReadData, rq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b);
    int   n;
    wr_t  e;
    MemWrite  = 1'b1;
    MemByte   = b;
    DataAdr   = a;
    WriteData = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (!Stall) break;
      n++;
      if (n > 500) begin
        chk("store_accept_timeout", 32'(Stall), 32'd0);
        MemWrite = 1'b0;
        return;
      end
      tick();
    end
    e.adr = a;
    e.b   = b;
    e.wd  = b ? {24'b0, d[7:0]} : d;
    wq.push_back(e);
    refm[a[7:2]] = e.wd;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = a;
    rq.push_back(exp);
    chk_load = 1'b1;
    @(negedge clk);
    tick();
    chk_load = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (Count != 3'd0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_count", 32'(Count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, a2, d;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'd0;
      refm[i] = 32'd0;
    end
    dmem[0]   = 32'h1234;
    refm[0]   = 32'h1234;
    reset     = 1'b0;
    MemWrite  = 1'b0;
    MemByte   = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    mem_ready = 1'b0;

    // Reset and passthrough
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_count",    32'(Count),  32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    chk("rst_stall",    32'(Stall),  32'd0);
    chk("rst_readdata", ReadData,    32'h1234);
    tick();
    load(32'd0, 32'h1234);

    // Forward a word store
    store(32'd100, 32'd254, 1'b0);
    load(32'd100, 32'd254);
    @(negedge clk);
    chk("fwd_count",   32'(Count),  32'd1);
    chk("fwd_mem_we",  32'(mem_we), 32'd1);
    chk("fwd_mem_adr", mem_adr,     32'd100);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("fwd_drained", 32'(Count), 32'd0);
    tick();
    load(32'd100, 32'd254);

    // Youngest match wins
    store(32'd96, 32'd5,      1'b0);
    store(32'd96, 32'd7,      1'b0);
    store(32'd96, 32'h1FF,    1'b1);
    load(32'd96, 32'h000000FF);
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("young_count", 32'(Count), 32'd0);
    tick();
    mem_ready = 1'b0;

    // Full stall
    store(32'd128, 32'd11, 1'b0);
    store(32'd132, 32'd22, 1'b0);
    store(32'd136, 32'd33, 1'b0);
    store(32'd140, 32'd44, 1'b0);
    MemWrite  = 1'b1;
    MemByte   = 1'b0;
    DataAdr   = 32'd144;
    WriteData = 32'd55;
    @(negedge clk);
    chk("full_stall", 32'(Stall), 32'd1);
    chk("full_count", 32'(Count), 32'd4);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("full_release", 32'(Stall), 32'd0);
    begin
      wr_t e;
      e.adr = 32'd144;
      e.b   = 1'b0;
      e.wd  = 32'd55;
      wq.push_back(e);
      refm[36] = 32'd55;
    end
    tick();
    MemWrite  = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("full_count_after", 32'(Count), 32'd4);
    tick();
    load(32'd144, 32'd55);
    mem_ready = 1'b1;
    wait_drain();
    mem_ready = 1'b0;

    // Reset mid-drain
    store(32'd200, 32'hA1,  1'b0);
    store(32'd204, 32'hA2,  1'b0);
    store(32'd208, 32'h3C3, 1'b1);
    @(negedge clk);
    chk("mid_count", 32'(Count), 32'd3);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_count",  32'(Count),  32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    wq.delete();
    for (int i = 0; i < 64; i++) refm[i] = dmem[i];
    tick();
    load(32'd200, 32'd0);
    load(32'd208, 32'd0);
    mem_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("mid_no_write", 32'(mem_we), 32'd0);
    tick();
    mem_ready = 1'b0;

    // Drain ordering under random mem_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a  = 32'd64 + 32'd4 * 32'((i * 5) % 8);
      a2 = 32'd64 + 32'd4 * 32'((i * 3) % 8);
      d  = 32'hA000_0000 + 32'(i) * 32'h0101_0103;
      store(a, d, (i % 4) == 3);
      load(a2, refm[a2[7:2]]);
    end
    rand_mode = 1'b0;
    mem_ready = 1'b1;
    wait_drain();
    tick();
    chk("wq_empty", 32'(wq.size()), 32'd0);
    for (int j = 0; j < 8; j++) begin
      a = 32'd64 + 32'd4 * 32'(j);
      load(a, refm[a[7:2]]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
